// File: rtl/cpu_pkg.sv
// Shared definitions for the 16-bit core: microword field positions, microcode
// geometry defaults and the microcode sequencer state encoding.
package cpu_pkg;

    localparam int UC_END                 = 0;
    localparam int UC_IMM_EXTEND_NEGATIVE = 5;
    localparam int UC_IMM_SHIFT           = 6;

    localparam int UADDR_W_DEF = 10;
    localparam int UC_W_DEF    = 28;
    localparam int PHASE_W     = 3;

    typedef enum logic [1:0] {
        UC_IDLE    = 2'd0,
        UC_EXEC    = 2'd1,
        UC_HALTED  = 2'd2,
        UC_WAITING = 2'd3
    } uc_seq_state_t;

endpackage

// File: rtl/uc_sequencer.sv
// Microcode sequencer: walks one instruction's microprogram in the external ROM.
// Optional feature macro: UC_SEQ_OVERRUN_CHECK_EN (forced end at phase 7 + sticky uc_overrun).
module uc_sequencer
    import cpu_pkg::*;
#(
    parameter int UADDR_W = UADDR_W_DEF,
    parameter int UC_W    = UC_W_DEF
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               instr_valid,
    output logic               instr_ready,
    input  logic [UADDR_W-1:0] ucode_addr,
    input  logic               halt,
    input  logic               wait_req,
    input  logic               irq,
    output logic [UADDR_W-1:0] rom_addr,
    input  logic [UC_W-1:0]    rom_data,
    output logic [UC_W-1:0]    ucommand,
    output logic [2:0]         phase,
    output logic               uc_valid,
`ifdef UC_SEQ_OVERRUN_CHECK_EN
    output logic               uc_overrun,
`endif
    output logic               halted,
    output logic               waiting
);

    localparam logic [UADDR_W-1:0] ADDR_ONE   = {{(UADDR_W-1){1'b0}}, 1'b1};
    localparam logic [UADDR_W-1:0] ADDR_EIGHT = {{(UADDR_W-4){1'b0}}, 4'd8};

    uc_seq_state_t      state_r, state_nxt_s;
    logic [UADDR_W-1:0] base_r, base_nxt_s;
    logic [2:0]         phase_r, phase_nxt_s;
    logic [UADDR_W-1:0] phase_ext_s;
    logic               uc_end_s;
    logic               final_s;
    logic               overrun_set_s;
`ifdef UC_SEQ_OVERRUN_CHECK_EN
    logic               overrun_r;
`endif

    // State, base and phase registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= UC_IDLE;
            base_r  <= {UADDR_W{1'b0}};
            phase_r <= 3'd0;
        end else begin
            state_r <= state_nxt_s;
            base_r  <= base_nxt_s;
            phase_r <= phase_nxt_s;
        end
    end

`ifdef UC_SEQ_OVERRUN_CHECK_EN
    // Sticky overrun flag, cleared only by reset
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            overrun_r <= 1'b0;
        end else if (overrun_set_s) begin
            overrun_r <= 1'b1;
        end else begin
            overrun_r <= overrun_r;
        end
    end

    assign uc_overrun = overrun_r;
`endif

    // Final-microstep detection; phase 7 without UC_END is an overrun when checking is built in
    always_comb begin
        uc_end_s      = rom_data[UC_END];
        overrun_set_s = 1'b0;
`ifdef UC_SEQ_OVERRUN_CHECK_EN
        final_s = uc_end_s || (phase_r == 3'd7);
        if ((state_r == UC_EXEC) && !uc_end_s && (phase_r == 3'd7)) begin
            overrun_set_s = 1'b1;
        end else begin
            overrun_set_s = 1'b0;
        end
`else
        final_s = uc_end_s;
`endif
    end

    // Next-state, prefetch address and bookkeeping
    always_comb begin
        state_nxt_s = state_r;
        base_nxt_s  = base_r;
        phase_nxt_s = phase_r;
        phase_ext_s = {{(UADDR_W-3){1'b0}}, phase_r};
        // Speculative prefetch of the next microword; wraps modulo 2^UADDR_W
        rom_addr    = base_r + phase_ext_s + ADDR_ONE;
        case (state_r)
            UC_IDLE: begin
                rom_addr = ucode_addr;
                if (instr_valid) begin
                    base_nxt_s  = ucode_addr;
                    phase_nxt_s = 3'd0;
                    state_nxt_s = UC_EXEC;
                end else begin
                    state_nxt_s = UC_IDLE;
                end
            end
            UC_EXEC: begin
                if (final_s) begin
                    phase_nxt_s = 3'd0;
                    if (halt) begin
                        state_nxt_s = UC_HALTED;
                    end else if (wait_req) begin
                        state_nxt_s = UC_WAITING;
                    end else begin
                        state_nxt_s = UC_IDLE;
                    end
                end else begin
                    phase_nxt_s = phase_r + 3'd1;
                    // On a 7->0 wrap the next window of eight microwords starts at base+8
                    if (phase_r == 3'd7) begin
                        base_nxt_s = base_r + ADDR_EIGHT;
                    end else begin
                        base_nxt_s = base_r;
                    end
                end
            end
            UC_HALTED: begin
                state_nxt_s = UC_HALTED;
            end
            UC_WAITING: begin
                if (irq) begin
                    state_nxt_s = UC_IDLE;
                end else begin
                    state_nxt_s = UC_WAITING;
                end
            end
            default: begin
                state_nxt_s = UC_IDLE;
                phase_nxt_s = 3'd0;
            end
        endcase
    end

    // Status outputs decoded directly from registered state
    always_comb begin
        instr_ready = (state_r == UC_IDLE);
        uc_valid    = (state_r == UC_EXEC);
        halted      = (state_r == UC_HALTED);
        waiting     = (state_r == UC_WAITING);
        phase       = phase_r;
        if (state_r == UC_EXEC) begin
            ucommand = rom_data;
        end else begin
            ucommand = {UC_W{1'b0}};
        end
    end

endmodule

// File: tb/tb_uc_sequencer.sv
// Directed self-checking bench for uc_sequencer with a behavioural synchronous ROM.
// Checks both builds of the UC_SEQ_OVERRUN_CHECK_EN feature.
module tb_uc_sequencer;
    import cpu_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        instr_valid;
    logic        instr_ready;
    logic [9:0]  ucode_addr;
    logic        halt;
    logic        wait_req;
    logic        irq;
    logic [9:0]  rom_addr;
    logic [27:0] rom_data;
    logic [27:0] ucommand;
    logic [2:0]  phase;
    logic        uc_valid;
    logic        halted;
    logic        waiting;
`ifdef UC_SEQ_OVERRUN_CHECK_EN
    logic        uc_overrun;
`endif

    logic [27:0] rom_mem [0:1023];
    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    // Synchronous ROM: data for the address presented at an edge appears after it
    always_ff @(posedge clk) rom_data <= rom_mem[rom_addr];

    uc_sequencer dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .instr_valid (instr_valid),
        .instr_ready (instr_ready),
        .ucode_addr  (ucode_addr),
        .halt        (halt),
        .wait_req    (wait_req),
        .irq         (irq),
        .rom_addr    (rom_addr),
        .rom_data    (rom_data),
        .ucommand    (ucommand),
        .phase       (phase),
        .uc_valid    (uc_valid),
`ifdef UC_SEQ_OVERRUN_CHECK_EN
        .uc_overrun  (uc_overrun),
`endif
        .halted      (halted),
        .waiting     (waiting)
    );

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        n_tests++;
        if (obs !== exp_v) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp_v);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Present an instruction in IDLE, check the entry address, and issue it
    task automatic issue(input logic [9:0] addr, input string tag);
        instr_valid = 1'b1;
        ucode_addr  = addr;
        #1;
        check_eq({tag, "_ready"}, {31'd0, instr_ready}, 32'd1);
        check_eq({tag, "_rom_addr_entry"}, {22'd0, rom_addr}, {22'd0, addr});
        tick();
        instr_valid = 1'b0;
    endtask

    task automatic exec_check(input string tag, input logic [2:0] ph,
                              input logic [27:0] word, input logic [9:0] nxt);
        check_eq({tag, "_uc_valid"}, {31'd0, uc_valid}, 32'd1);
        check_eq({tag, "_phase"}, {29'd0, phase}, {29'd0, ph});
        check_eq({tag, "_ucommand"}, {4'd0, ucommand}, {4'd0, word});
        check_eq({tag, "_rom_addr"}, {22'd0, rom_addr}, {22'd0, nxt});
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        #1;
        check_eq("rst_ready", {31'd0, instr_ready}, 32'd1);
        check_eq("rst_uc_valid", {31'd0, uc_valid}, 32'd0);
        check_eq("rst_ucommand", {4'd0, ucommand}, 32'd0);
        check_eq("rst_phase", {29'd0, phase}, 32'd0);
        check_eq("rst_halted", {31'd0, halted}, 32'd0);
        check_eq("rst_waiting", {31'd0, waiting}, 32'd0);
        check_eq("rst_rom_addr", {22'd0, rom_addr}, {22'd0, ucode_addr});
        #1;
        rst_n = 1'b1;
    endtask

    initial begin
        for (int i = 0; i < 1024; i++) rom_mem[i] = 28'h0;
        // 3-step program at 0x040
        rom_mem[10'h040] = 28'h0A00010;
        rom_mem[10'h041] = 28'h0B00020;
        rom_mem[10'h042] = 28'h0C00031;
        // 2-step program at 0x080
        rom_mem[10'h080] = 28'h0D00040;
        rom_mem[10'h081] = 28'h0E00051;
        // 1-step program at 0x0C0
        rom_mem[10'h0C0] = 28'h0F00061;
        // Program straddling the top of the address space
        rom_mem[10'h3FE] = 28'h1100070;
        rom_mem[10'h3FF] = 28'h1200080;
        rom_mem[10'h000] = 28'h1300091;
        // Program with no UC_END in its first eight words
        for (int i = 0; i < 8; i++) rom_mem[10'h100 + i] = 28'h1400000 + 28'(i << 4);
        rom_mem[10'h108] = 28'h15000A1;
        // 4-step program used for mid-instruction reset
        rom_mem[10'h140] = 28'h16000B0;
        rom_mem[10'h141] = 28'h17000C0;
        rom_mem[10'h142] = 28'h18000D0;
        rom_mem[10'h143] = 28'h19000E1;

        instr_valid = 1'b0;
        ucode_addr  = 10'h040;
        halt        = 1'b0;
        wait_req    = 1'b0;
        irq         = 1'b0;
        do_reset();
        tick();

        // Basic 3-step instruction
        issue(10'h040, "t1");
        exec_check("t1_s0", 3'd0, 28'h0A00010, 10'h041);
        tick();
        exec_check("t1_s1", 3'd1, 28'h0B00020, 10'h042);
        tick();
        exec_check("t1_s2", 3'd2, 28'h0C00031, 10'h043);
        tick();
        check_eq("t1_idle_ready", {31'd0, instr_ready}, 32'd1);
        check_eq("t1_idle_uc_valid", {31'd0, uc_valid}, 32'd0);
        check_eq("t1_idle_ucommand", {4'd0, ucommand}, 32'd0);

        // halt and wait_req on a non-final step are ignored; on the final step halt wins
        issue(10'h080, "t2");
        halt     = 1'b1;
        wait_req = 1'b1;
        exec_check("t2_s0", 3'd0, 28'h0D00040, 10'h081);
        tick();
        exec_check("t2_s1", 3'd1, 28'h0E00051, 10'h082);
        tick();
        halt        = 1'b0;
        wait_req    = 1'b0;
        instr_valid = 1'b1;
        irq         = 1'b1;
        for (int i = 0; i < 4; i++) begin
            check_eq("t2_halted", {31'd0, halted}, 32'd1);
            check_eq("t2_waiting", {31'd0, waiting}, 32'd0);
            check_eq("t2_ready", {31'd0, instr_ready}, 32'd0);
            check_eq("t2_uc_valid", {31'd0, uc_valid}, 32'd0);
            tick();
        end
        instr_valid = 1'b0;
        irq         = 1'b0;
        do_reset();
        tick();

        // wait_req on the final step parks in WAITING until irq
        wait_req = 1'b1;
        issue(10'h0C0, "t3");
        exec_check("t3_s0", 3'd0, 28'h0F00061, 10'h0C1);
        tick();
        wait_req = 1'b0;
        for (int i = 0; i < 5; i++) begin
            check_eq("t3_waiting", {31'd0, waiting}, 32'd1);
            check_eq("t3_uc_valid", {31'd0, uc_valid}, 32'd0);
            check_eq("t3_ready", {31'd0, instr_ready}, 32'd0);
            tick();
        end
        irq = 1'b1;
        #1;
        check_eq("t3_still_waiting", {31'd0, waiting}, 32'd1);
        tick();
        irq = 1'b0;
        check_eq("t3_woke", {31'd0, waiting}, 32'd0);
        check_eq("t3_ready_after_irq", {31'd0, instr_ready}, 32'd1);

        // ROM address wraps at the top of the address space
        issue(10'h3FE, "t4");
        exec_check("t4_s0", 3'd0, 28'h1100070, 10'h3FF);
        tick();
        exec_check("t4_s1", 3'd1, 28'h1200080, 10'h000);
        tick();
        exec_check("t4_s2", 3'd2, 28'h1300091, 10'h001);
        tick();
        check_eq("t4_idle", {31'd0, instr_ready}, 32'd1);

        // Program without UC_END within eight steps
        issue(10'h100, "t5");
        for (int i = 0; i < 8; i++) begin
`ifdef UC_SEQ_OVERRUN_CHECK_EN
            check_eq("t5_no_overrun_yet", {31'd0, uc_overrun}, 32'd0);
`endif
            exec_check("t5_step", 3'(i), 28'h1400000 + 28'(i << 4), 10'(10'h101 + i));
            tick();
        end
`ifdef UC_SEQ_OVERRUN_CHECK_EN
        check_eq("t5_forced_end", {31'd0, uc_valid}, 32'd0);
        check_eq("t5_ready", {31'd0, instr_ready}, 32'd1);
        check_eq("t5_overrun", {31'd0, uc_overrun}, 32'd1);
        tick();
        check_eq("t5_overrun_sticky", {31'd0, uc_overrun}, 32'd1);
`else
        exec_check("t5_wrap", 3'd0, 28'h15000A1, 10'h109);
        tick();
        check_eq("t5_end_ready", {31'd0, instr_ready}, 32'd1);
`endif

        // Reset in the middle of an instruction discards it
        issue(10'h140, "t6");
        tick();
        tick();
        exec_check("t6_s2", 3'd2, 28'h18000D0, 10'h143);
        ucode_addr = 10'h040;
        do_reset();
        tick();
        issue(10'h040, "t6b");
        exec_check("t6b_s0", 3'd0, 28'h0A00010, 10'h041);
        tick();
        tick();
        tick();
        check_eq("t6b_idle", {31'd0, instr_ready}, 32'd1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
